// File: rtl/multicycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_pkg
//  Description : Shared types and encodings for the RV32I multicycle control
//                unit: FSM state enum, opcode values, ALU control codes and
//                datapath mux select encodings, plus small decode helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package multicycle_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWRITE = 4'd4,
        MEMWB    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10
    } state_t;

    // Opcodes supported by this core
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ALU control codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Internal ALU operation class handed to the ALU decoder
    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    // Mux select encodings
    localparam logic       ADR_PC        = 1'b0;
    localparam logic       ADR_ALUOUT    = 1'b1;
    localparam logic [1:0] SRCA_PC       = 2'b00;
    localparam logic [1:0] SRCA_OLDPC    = 2'b01;
    localparam logic [1:0] SRCA_RD1      = 2'b10;
    localparam logic [1:0] SRCB_RD2      = 2'b00;
    localparam logic [1:0] SRCB_IMM      = 2'b01;
    localparam logic [1:0] SRCB_FOUR     = 2'b10;
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] IMM_I         = 2'b00;
    localparam logic [1:0] IMM_S         = 2'b01;
    localparam logic [1:0] IMM_B         = 2'b10;
    localparam logic [1:0] IMM_J         = 2'b11;

    // Purely state-dependent outputs; held in registers inside the FSM
    typedef struct packed {
        logic       adr_src;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } moore_t;

    function automatic moore_t moore_decode(input state_t s);
        moore_t m;
        m = '0;
        case (s)
            FETCH: begin
                m.adr_src    = ADR_PC;
                m.alu_src_a  = SRCA_PC;
                m.alu_src_b  = SRCB_FOUR;
                m.alu_op     = ALUOP_ADD;
                m.result_src = RES_ALURESULT;
            end
            DECODE: begin
                // Branch target precomputed as old_pc + imm
                m.alu_src_a = SRCA_OLDPC;
                m.alu_src_b = SRCB_IMM;
                m.alu_op    = ALUOP_ADD;
            end
            MEMADR: begin
                m.alu_src_a = SRCA_RD1;
                m.alu_src_b = SRCB_IMM;
                m.alu_op    = ALUOP_ADD;
            end
            MEMREAD: begin
                m.adr_src    = ADR_ALUOUT;
                m.result_src = RES_ALUOUT;
            end
            MEMWRITE: begin
                m.adr_src    = ADR_ALUOUT;
                m.result_src = RES_ALUOUT;
                m.mem_write  = 1'b1;
            end
            MEMWB: begin
                m.result_src = RES_DATA;
                m.reg_write  = 1'b1;
            end
            EXECUTER: begin
                m.alu_src_a = SRCA_RD1;
                m.alu_src_b = SRCB_RD2;
                m.alu_op    = ALUOP_FUNC;
            end
            EXECUTEI: begin
                m.alu_src_a = SRCA_RD1;
                m.alu_src_b = SRCB_IMM;
                m.alu_op    = ALUOP_FUNC;
            end
            ALUWB: begin
                m.result_src = RES_ALUOUT;
                m.reg_write  = 1'b1;
            end
            BRANCH: begin
                m.alu_src_a  = SRCA_RD1;
                m.alu_src_b  = SRCB_RD2;
                m.alu_op     = ALUOP_SUB;
                m.result_src = RES_ALUOUT;
            end
            JAL: begin
                m.alu_src_a  = SRCA_OLDPC;
                m.alu_src_b  = SRCB_FOUR;
                m.alu_op     = ALUOP_ADD;
                m.result_src = RES_ALUOUT;
            end
            default: m = '0;
        endcase
        return m;
    endfunction

    function automatic logic [1:0] imm_decode(input logic [6:0] op);
        logic [1:0] r;
        case (op)
            OP_STORE:  r = IMM_S;
            OP_BRANCH: r = IMM_B;
            OP_JAL:    r = IMM_J;
            default:   r = IMM_I;
        endcase
        return r;
    endfunction

    function automatic logic op_legal(input logic [6:0] op);
        logic r;
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl_if
//  Description : Control bus between the multicycle controller and datapath.
//                master : controller side (drives selects/strobes/instret)
//                slave  : datapath side (drives instruction fields, zero,
//                         mem_ready)
//  Ports       : op[6:0], funct3[2:0], funct7b5, zero, mem_ready (to ctrl);
//                pc_write, adr_src, mem_write, ir_write, result_src[1:0],
//                alu_src_a[1:0], alu_src_b[1:0], alu_control[2:0],
//                imm_src[1:0], reg_write, illegal, instret[CNT_W-1:0]
//  Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       op;
    logic [2:0]       funct3;
    logic             funct7b5;
    logic             zero;
    logic             mem_ready;

    logic             pc_write;
    logic             adr_src;
    logic             mem_write;
    logic             ir_write;
    logic [1:0]       result_src;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [2:0]       alu_control;
    logic [1:0]       imm_src;
    logic             reg_write;
    logic             illegal;
    logic [CNT_W-1:0] instret;

    modport master (
        input  op, funct3, funct7b5, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_control, imm_src, reg_write,
               illegal, instret
    );

    modport slave (
        output op, funct3, funct7b5, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_control, imm_src, reg_write,
               illegal, instret
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl_alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : alu_decoder
//  Description : Maps the FSM's ALU operation class plus instruction fields
//                to the 3-bit ALU control code.
//  Ports       : alu_op[1:0], funct3[2:0], funct7b5, op5 (in)
//                alu_control[2:0] (out)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
    import multicycle_pkg::*;
(
    input  wire logic [1:0] alu_op,
    input  wire logic [2:0] funct3,
    input  wire logic       funct7b5,
    input  wire logic       op5,
    output logic      [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNC: begin
                case (funct3)
                    // funct7b5 only means sub for register-register ops;
                    // addi keeps an immediate bit there.
                    3'b000:  alu_control = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Main control FSM of the RV32I multicycle core. Sequences
//                fetch/decode/execute/memory/writeback, drives datapath mux
//                selects and write strobes, absorbs memory wait states and
//                counts retired instructions.
//  Ports       : clk   - core clock, rising edge
//                rst_n - asynchronous active-low reset
//                bus   - multicycle_ctrl_if.master (instruction fields, zero,
//                        mem_ready in; selects, strobes, illegal, instret out)
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    multicycle_ctrl_if.master  bus
);

    state_t           r_state;
    state_t           w_next;
    moore_t           r_moore;
    logic [CNT_W-1:0] r_instret;
    logic             w_retire;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            FETCH:    w_next = bus.mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (bus.op)
                    OP_LOAD, OP_STORE: w_next = MEMADR;
                    OP_RTYPE:          w_next = EXECUTER;
                    OP_ITYPE:          w_next = EXECUTEI;
                    OP_BRANCH:         w_next = BRANCH;
                    OP_JAL:            w_next = JAL;
                    default:           w_next = FETCH;
                endcase
            end
            MEMADR:   w_next = (bus.op == OP_LOAD) ? MEMREAD : MEMWRITE;
            MEMREAD:  w_next = bus.mem_ready ? MEMWB : MEMREAD;
            MEMWRITE: w_next = bus.mem_ready ? FETCH : MEMWRITE;
            MEMWB:    w_next = FETCH;
            EXECUTER: w_next = ALUWB;
            EXECUTEI: w_next = ALUWB;
            ALUWB:    w_next = FETCH;
            BRANCH:   w_next = FETCH;
            JAL:      w_next = ALUWB;
            default:  w_next = FETCH;
        endcase
    end

    // Retirement is the return to FETCH from a completing state; an illegal
    // opcode returns from DECODE and therefore never counts.
    always_comb begin
        w_retire = 1'b0;
        if (w_next == FETCH) begin
            case (r_state)
                MEMWB, MEMWRITE, ALUWB, BRANCH: w_retire = 1'b1;
                default:                        w_retire = 1'b0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State, registered Moore outputs and retired-instruction counter.
    // The Moore register is loaded from the next state so it always
    // reflects the current state without a decode path on the outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= FETCH;
            r_moore   <= moore_decode(FETCH);
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            r_moore <= moore_decode(w_next);
            if (w_retire) begin
                r_instret <= r_instret + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Input-dependent strobes. These depend on mem_ready, zero or op in the
    // same cycle, so they cannot be registered; they are gated with rst_n so
    // nothing fires while reset holds the FSM in FETCH.
    // ------------------------------------------------------------------
    logic w_in_fetch;
    logic w_fetch_done;
    logic w_branch_taken;

    assign w_in_fetch     = (r_state == FETCH);
    assign w_fetch_done   = w_in_fetch & bus.mem_ready;
    // beq takes on zero, bne on !zero; funct3[0] distinguishes them
    assign w_branch_taken = (r_state == BRANCH) & (bus.zero ^ bus.funct3[0]);

    assign bus.pc_write  = rst_n & (w_fetch_done | w_branch_taken | (r_state == JAL));
    assign bus.ir_write  = rst_n & w_fetch_done;
    assign bus.illegal   = rst_n & (r_state == DECODE) & ~op_legal(bus.op);
    assign bus.mem_write = rst_n & r_moore.mem_write;
    assign bus.reg_write = rst_n & r_moore.reg_write;

    assign bus.adr_src    = r_moore.adr_src;
    assign bus.result_src = r_moore.result_src;
    assign bus.alu_src_a  = r_moore.alu_src_a;
    assign bus.alu_src_b  = r_moore.alu_src_b;
    assign bus.imm_src    = imm_decode(bus.op);
    assign bus.instret    = r_instret;

    alu_decoder u_alu_decoder (
        .alu_op      (r_moore.alu_op),
        .funct3      (bus.funct3),
        .funct7b5    (bus.funct7b5),
        .op5         (bus.op[5]),
        .alu_control (bus.alu_control)
    );

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Directed self-checking bench for multicycle_ctrl. Each step
//                pushes the expected state/outputs/instret for the cycle to a
//                scoreboard queue; the entry is popped and compared on the
//                falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;
    import multicycle_pkg::*;

    localparam int CNT_W = 32;

    logic clk;
    logic rst_n;

    multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        state_t      st;
        logic [16:0] vec;
        logic [31:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_instret = 0;

    // Expected outputs for one cycle, written from the control table:
    // {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
    //  alu_src_b, alu_control, imm_src, reg_write, illegal}
    function automatic logic [16:0] spec_out(input state_t s, input logic mr,
                                             input logic z, input logic [2:0] f3,
                                             input logic f7, input logic [6:0] o);
        logic       pcw, adr, mw, irw, rw, ill;
        logic [1:0] res, sa, sb, aop, imm;
        logic [2:0] ac;
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
        res = 2'b00; sa = 2'b00; sb = 2'b00; aop = 2'b00;
        case (s)
            FETCH:    begin sb = 2'b10; res = 2'b10; irw = mr; pcw = mr; end
            DECODE:   begin
                sa = 2'b01; sb = 2'b01;
                ill = !(o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
                        o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111);
            end
            MEMADR:   begin sa = 2'b10; sb = 2'b01; end
            MEMREAD:  begin adr = 1; end
            MEMWRITE: begin adr = 1; mw = 1; end
            MEMWB:    begin res = 2'b01; rw = 1; end
            EXECUTER: begin sa = 2'b10; sb = 2'b00; aop = 2'b10; end
            EXECUTEI: begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
            ALUWB:    begin rw = 1; end
            BRANCH:   begin sa = 2'b10; aop = 2'b01; pcw = z ^ f3[0]; end
            JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1; end
            default:  ;
        endcase
        ac = 3'b000;
        if (aop == 2'b01) ac = 3'b001;
        else if (aop == 2'b10) begin
            case (f3)
                3'b000:  ac = (f7 && o[5]) ? 3'b001 : 3'b000;
                3'b010:  ac = 3'b101;
                3'b110:  ac = 3'b011;
                3'b111:  ac = 3'b010;
                default: ac = 3'b000;
            endcase
        end
        case (o)
            7'b0100011: imm = 2'b01;
            7'b1100011: imm = 2'b10;
            7'b1101111: imm = 2'b11;
            default:    imm = 2'b00;
        endcase
        return {pcw, adr, mw, irw, res, sa, sb, ac, imm, rw, ill};
    endfunction

    function automatic logic [16:0] observed();
        return {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write,
                bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.alu_control,
                bus.imm_src, bus.reg_write, bus.illegal};
    endfunction

    task automatic check_head();
        exp_t e;
        e = exp_q.pop_front();
        vectors++;
        assert (dut.r_state === e.st) else begin
            miscompares++;
            $error("FAIL state: observed %0d expected %0d", dut.r_state, e.st);
        end
        vectors++;
        assert (observed() === e.vec) else begin
            miscompares++;
            $error("FAIL outputs(st=%0d): observed %05h expected %05h", e.st, observed(), e.vec);
        end
        vectors++;
        assert (bus.instret === e.cnt) else begin
            miscompares++;
            $error("FAIL instret(st=%0d): observed %0d expected %0d", e.st, bus.instret, e.cnt);
        end
    endtask

    // One clock cycle: drive mem_ready, record expectation, compare at negedge
    task automatic step(input state_t s, input logic mr, input bit retire);
        exp_t e;
        bus.mem_ready = mr;
        e.st  = s;
        e.vec = spec_out(s, mr, bus.zero, bus.funct3, bus.funct7b5, bus.op);
        e.cnt = exp_instret;
        exp_q.push_back(e);
        @(negedge clk);
        check_head();
        if (retire) exp_instret = exp_instret + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        bus.op       = o;
        bus.funct3   = f3;
        bus.funct7b5 = f7;
    endtask

    task automatic check_reset(input string tag);
        vectors++;
        assert (dut.r_state === FETCH && bus.instret === '0) else begin
            miscompares++;
            $error("FAIL %s state/instret: observed %0d/%0d expected 0/0", tag, dut.r_state, bus.instret);
        end
        vectors++;
        assert ({bus.pc_write, bus.ir_write, bus.mem_write, bus.reg_write, bus.illegal} === 5'b0) else begin
            miscompares++;
            $error("FAIL %s strobes: observed %05b expected 00000", tag,
                   {bus.pc_write, bus.ir_write, bus.mem_write, bus.reg_write, bus.illegal});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.mem_ready = 1'b1;
        bus.zero      = 1'b0;
        set_instr(7'b0110011, 3'b000, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset("por");
        rst_n = 1'b1;

        // add; mem_ready low in DECODE/EXECUTER must be ignored
        set_instr(7'b0110011, 3'b000, 1'b0);
        step(FETCH, 1, 0); step(DECODE, 0, 0); step(EXECUTER, 0, 0); step(ALUWB, 1, 1);

        // sub
        set_instr(7'b0110011, 3'b000, 1'b1);
        step(FETCH, 1, 0); step(DECODE, 1, 0); step(EXECUTER, 1, 0); step(ALUWB, 1, 1);

        // addi with funct7b5 set stays add
        set_instr(7'b0010011, 3'b000, 1'b1);
        step(FETCH, 1, 0); step(DECODE, 1, 0); step(EXECUTEI, 1, 0); step(ALUWB, 1, 1);

        // slti, or, and
        set_instr(7'b0010011, 3'b010, 1'b0);
        step(FETCH, 1, 0); step(DECODE, 1, 0); step(EXECUTEI, 1, 0); step(ALUWB, 1, 1);
        set_instr(7'b0110011, 3'b110, 1'b0);
        step(FETCH, 1, 0); step(DECODE, 1, 0); step(EXECUTER, 1, 0); step(ALUWB, 1, 1);
        set_instr(7'b0110011, 3'b111, 1'b0);
        step(FETCH, 1, 0); step(DECODE, 1, 0); step(EXECUTER, 1, 0); step(ALUWB, 1, 1);

        // lw: 2 wait cycles in FETCH, 3 in MEMREAD -> 10 cycles
        set_instr(7'b0000011, 3'b010, 1'b0);
        step(FETCH, 0, 0); step(FETCH, 0, 0); step(FETCH, 1, 0);
        step(DECODE, 1, 0); step(MEMADR, 1, 0);
        step(MEMREAD, 0, 0); step(MEMREAD, 0, 0); step(MEMREAD, 0, 0); step(MEMREAD, 1, 0);
        step(MEMWB, 0, 1);

        // sw: 1 wait cycle in MEMWRITE -> mem_write for 2 cycles
        set_instr(7'b0100011, 3'b010, 1'b0);
        step(FETCH, 1, 0); step(DECODE, 1, 0); step(MEMADR, 1, 0);
        step(MEMWRITE, 0, 0); step(MEMWRITE, 1, 1);

        // beq taken, bne not taken, both with zero=1
        bus.zero = 1'b1;
        set_instr(7'b1100011, 3'b000, 1'b0);
        step(FETCH, 1, 0); step(DECODE, 1, 0); step(BRANCH, 1, 1);
        set_instr(7'b1100011, 3'b001, 1'b0);
        step(FETCH, 1, 0); step(DECODE, 1, 0); step(BRANCH, 1, 1);
        // bne taken with zero=0
        bus.zero = 1'b0;
        step(FETCH, 1, 0); step(DECODE, 1, 0); step(BRANCH, 0, 1);

        // jal
        set_instr(7'b1101111, 3'b000, 1'b0);
        step(FETCH, 1, 0); step(DECODE, 1, 0); step(JAL, 1, 0); step(ALUWB, 1, 1);

        // illegal opcode: pulse in DECODE, back to FETCH, no retirement
        set_instr(7'h7F, 3'b000, 1'b0);
        step(FETCH, 1, 0); step(DECODE, 1, 0);
        set_instr(7'b0110011, 3'b000, 1'b0);
        step(FETCH, 1, 0); step(DECODE, 1, 0); step(EXECUTER, 1, 0); step(ALUWB, 1, 1);

        // Reset asserted in the middle of a load
        set_instr(7'b0000011, 3'b010, 1'b0);
        step(FETCH, 1, 0); step(DECODE, 1, 0); step(MEMADR, 1, 0); step(MEMREAD, 0, 0);
        bus.mem_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        check_reset("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_instret = 0;

        // Clean restart after reset
        set_instr(7'b0110011, 3'b000, 1'b0);
        step(FETCH, 1, 0); step(DECODE, 1, 0); step(EXECUTER, 1, 0); step(ALUWB, 1, 1);
        step(FETCH, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the 32-bit RV32I multicycle core. It sequences every instruction through fetch, decode, execute, memory and writeback. It drives the select lines of the shared 2:1 and 3:1 datapath muxes (address, ALU operands, result) and the write strobes. It also handles wait states on the unified instruction/data memory and keeps a retired-instruction counter.

Parameters:
CNT_W, 32, width of retired-instruction counter instret

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  7  instr[6:0] from the instruction register
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
zero  in  1  ALU zero flag, combinational from the ALU
mem_ready  in  1  memory completed the current access this cycle
pc_write  out  1  PC register enable
adr_src  out  1  address mux select: 0=PC, 1=alu_out
mem_write  out  1  memory write strobe
ir_write  out  1  IR and old_pc load enable
result_src  out  2  result mux select: 00=alu_out, 01=data, 10=alu_result
alu_src_a  out  2  ALU A select: 00=PC, 01=old_pc, 10=rd1
alu_src_b  out  2  ALU B select: 00=rd2, 01=imm, 10=const 4
alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
imm_src  out  2  00 I, 01 S, 10 B, 11 J; decoded combinationally from op
reg_write  out  1  register file write enable
illegal  out  1  one-cycle pulse on an unsupported opcode
instret  out  CNT_W  count of retired instructions

Behaviour:
- Reset (rst_n=0, async): state=FETCH, instret=0. While reset is asserted, pc_write, ir_write, mem_write, reg_write and illegal are forced to 0. After reset, selects take their FETCH values.
- Moore outputs are decoded from state. Any output not listed for a state is 0.
- FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10. ir_write and pc_write equal mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target precompute). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - any other op -> pulse illegal=1 and return to FETCH; instret does not change.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Go to MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Wait for mem_ready, then go to MEMWB.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1. mem_write is held every cycle until mem_ready=1, then go to FETCH.
- MEMWB: result_src=01, reg_write=1, then go to FETCH.
- EXECUTER and EXECUTEI: alu_src_a=10, alu_op=10. alu_src_b=00 in EXECUTER, 01 in EXECUTEI. Both go to ALUWB.
- ALUWB: result_src=00, reg_write=1, then go to FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00. pc_write = zero XOR funct3[0] (beq/bne only). Go to FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1. Go to ALUWB.
- ALU decode:
  - alu_op 00 -> add; alu_op 01 -> sub.
  - alu_op 10 by funct3: 000 gives sub if (funct7b5 & op[5]), else add; 010 -> slt; 110 -> or; 111 -> and.
  - Any other funct3 gives add.
- instret increments by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH. It wraps modulo 2^CNT_W.
- Latency: R/I-type 4 cycles, lw 5, sw 4, beq/bne 3, jal 4. Add 1 cycle per extra mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE.
- mem_ready is ignored in every state other than FETCH, MEMREAD and MEMWRITE.
- Reset mid-instruction: the FSM aborts immediately to FETCH. No partial strobe is issued in the cycle after release.

Decomposition:
- Package multicycle_pkg holds:
  - state_t enum (FETCH, DECODE, MEMADR, MEMREAD, MEMWRITE, MEMWB, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL)
  - opcode localparams
  - ALU_* control codes
  - SRCA_*, SRCB_*, RES_*, IMM_* select encodings
- One sub-module, alu_decoder: combinational mapping of (alu_op, funct3, funct7b5, op[5]) to alu_control.

Test Plan:
- Reset, then add (op=0110011, f3=000, f7b5=0), mem_ready=1 -> states FETCH, DECODE, EXECUTER, ALUWB. alu_control=000 in EXECUTER, reg_write=1 only in ALUWB, instret=1.
- sub (f7b5=1) then addi with f7b5=1 (op=0010011) -> alu_control=001 for sub, 000 for addi.
- lw with mem_ready low 2 cycles in FETCH and 3 in MEMREAD -> 10 cycles total. ir_write pulses once, reg_write with result_src=01 once.
- sw with mem_ready low 1 cycle in MEMWRITE -> mem_write=1 for exactly 2 cycles, adr_src=1.
- beq with zero=1 -> pc_write=1 in BRANCH; bne with zero=1 -> pc_write=0. instret increments for both.
- op=7'h7F -> illegal pulses 1 cycle in DECODE, next state FETCH, instret unchanged. Assert rst_n=0 during MEMREAD -> FETCH and instret=0 immediately, all strobes 0.
